// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the immediate extender/decoder.
// Keeps the PC, issues one instruction-memory request at a time, captures the
// returned word and presents it with its PC to decode. Redirects from execute
// replace the PC; a response that belongs to the old path is dropped.
//
// Optional feature (macro FETCH_MISALIGN_CHK_EN): a redirect whose target has
// nonzero low bits raises a sticky misalign_err and parks the FSM in HALT until
// reset. With the macro undefined the low bits are cleared and misalign_err
// is tied to 0.
//
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   imem_req_valid/ready, imem_addr    request channel to instruction memory
//   imem_rsp_valid, imem_rdata         response channel from instruction memory
//   redirect_valid, redirect_pc        one-cycle redirect pulse from execute
//   instr_valid/ready, instr, instr_pc instruction channel to decode
//   misalign_err                       sticky misaligned-redirect flag
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic            r_drop;
  logic            w_drop_nxt;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] w_instr_nxt;
  logic [XLEN-1:0] r_instr_pc;
  logic [XLEN-1:0] w_instr_pc_nxt;
  logic            r_instr_valid;
  logic            w_instr_valid_nxt;
  logic            w_req_valid;
  logic            w_halt_req;
  logic            w_bad;
  logic [XLEN-1:0] w_target;

  // Redirect target is always word aligned.
  assign w_target = redirect_pc & ALIGN_MASK;

`ifdef FETCH_MISALIGN_CHK_EN
  assign w_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign w_bad = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_drop        <= 1'b0;
      r_instr       <= NOP_INSTR;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_drop        <= w_drop_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_drop_nxt        = r_drop;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_req_valid       = 1'b0;
    w_halt_req        = 1'b0;

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;

      S_REQ: begin
        // A redirect suppresses the request so the stale PC never goes out.
        if (redirect_valid) begin
          if (w_bad) w_halt_req = 1'b1;
          else       w_pc_nxt   = w_target;
        end else begin
          w_req_valid = 1'b1;
          if (imem_req_ready) w_state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        if (w_bad) begin
          w_halt_req = 1'b1;
        end else if (imem_rsp_valid) begin
          if (r_drop || redirect_valid) begin
            // Wrong-path response: discard and refetch from the current PC.
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
            if (redirect_valid) w_pc_nxt = w_target;
          end else begin
            w_instr_nxt       = imem_rdata;
            w_instr_pc_nxt    = r_pc;
            w_pc_nxt          = r_pc + PC_STEP;
            w_instr_valid_nxt = 1'b1;
            w_state_nxt       = S_HOLD;
          end
        end else if (redirect_valid) begin
          // Response still in flight; remember to throw it away.
          w_pc_nxt   = w_target;
          w_drop_nxt = 1'b1;
        end
      end

      S_HOLD: begin
        // Redirect wins over a same-cycle decode handshake.
        if (redirect_valid) begin
          w_instr_valid_nxt = 1'b0;
          w_instr_nxt       = NOP_INSTR;
          if (w_bad) begin
            w_halt_req = 1'b1;
          end else begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_REQ;
          end
        end else if (instr_ready) begin
          w_instr_valid_nxt = 1'b0;
          w_instr_nxt       = NOP_INSTR;
          w_state_nxt       = S_REQ;
        end
      end

      S_HALT: w_state_nxt = S_HALT;

      default: w_state_nxt = S_IDLE;
    endcase

    // Misaligned redirect: park until reset, nothing presented downstream.
    if (w_halt_req) begin
      w_state_nxt       = S_HALT;
      w_drop_nxt        = 1'b0;
      w_instr_valid_nxt = 1'b0;
      w_instr_nxt       = NOP_INSTR;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= r_misalign | w_halt_req;
  end

  assign misalign_err = r_misalign;
`else
  assign misalign_err = 1'b0;
`endif

  assign imem_req_valid = w_req_valid;
  assign imem_addr      = r_pc;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000 ^ (a << 7);
  endfunction

  logic [31:0] mem_addr;
  assign imem_rdata = mem_word(mem_addr);

  int tests;
  int fails;
  int cyc;
  logic [31:0] req_log[$];
  logic [31:0] hs_pc[$];
  int          hs_cyc[$];

  // Transaction-level model of the fetch stage.
  bit          m_started, m_busy, m_drop, m_have, m_halt, m_mis;
  logic [31:0] m_pc, m_ipc, m_instr, m_req_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_true(input string nm, input bit ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0 expected 1 (cycle %0d)", nm, cyc);
    end
  endtask

  // Per-cycle compare against the model, then advance the model.
  initial begin
    bit          bad;
    bit          exp_req;
    logic [31:0] tgt;
    cyc      = 0;
    mem_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        m_started = 0; m_busy = 0; m_drop = 0; m_have = 0; m_halt = 0; m_mis = 0;
        m_pc = 32'h0; m_ipc = 32'h0; m_instr = NOP; m_req_addr = 32'h0;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, NOP);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misalign", misalign_err, 1'b0);
      end else begin
        exp_req = m_started && !m_halt && !m_busy && !m_have && !redirect_valid;
        chk("req_valid", imem_req_valid, exp_req);
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, m_have);
        chk("instr", instr, m_have ? m_instr : NOP);
        chk("instr_pc", instr_pc, m_ipc);
        chk("misalign_err", misalign_err, m_mis);

        if (imem_req_valid && imem_req_ready) begin
          req_log.push_back(imem_addr);
          mem_addr = imem_addr;
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
          hs_pc.push_back(instr_pc);
          hs_cyc.push_back(cyc);
        end

`ifdef FETCH_MISALIGN_CHK_EN
        bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
        bad = 1'b0;
`endif
        tgt = {redirect_pc[31:2], 2'b00};
        if (!m_started) begin
          m_started = 1;
        end else if (m_halt) begin
          // parked until reset
        end else if (m_have) begin
          if (redirect_valid) begin
            m_have = 0;
            if (bad) begin m_halt = 1; m_mis = 1; end
            else m_pc = tgt;
          end else if (instr_ready) begin
            m_have = 0;
          end
        end else if (m_busy) begin
          if (bad) begin
            m_busy = 0; m_drop = 0; m_halt = 1; m_mis = 1;
          end else if (imem_rsp_valid) begin
            m_busy = 0;
            if (m_drop || redirect_valid) begin
              m_drop = 0;
              if (redirect_valid) m_pc = tgt;
            end else begin
              m_have  = 1;
              m_ipc   = m_req_addr;
              m_instr = mem_word(m_req_addr);
              m_pc    = m_req_addr + 32'd4;
            end
          end else if (redirect_valid) begin
            m_pc   = tgt;
            m_drop = 1;
          end
        end else begin
          if (redirect_valid) begin
            if (bad) begin m_halt = 1; m_mis = 1; end
            else m_pc = tgt;
          end else if (imem_req_ready) begin
            m_busy     = 1;
            m_req_addr = m_pc;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req_log.delete();
    hs_pc.delete();
    hs_cyc.delete();
    @(negedge clk);
  endtask

  task automatic wait_req(input int n, input string nm);
    int k = 0;
    while (req_log.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk_true(nm, req_log.size() >= n);
  endtask

  task automatic wait_hs(input int n, input string nm);
    int k = 0;
    while (hs_pc.size() < n && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk_true(nm, hs_pc.size() >= n);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!instr_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk_true(nm, instr_valid);
  endtask

  initial begin
    logic [31:0] held;
    int          n;
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;

    // Streaming with zero-latency memory and always-ready decode.
    do_reset();
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; instr_ready = 1'b1;
    repeat (12) @(negedge clk);
    chk_true("t1_req_count", req_log.size() >= 3);
    if (req_log.size() >= 3) begin
      chk("t1_req0", req_log[0], 32'h0);
      chk("t1_req1", req_log[1], 32'h4);
      chk("t1_req2", req_log[2], 32'h8);
    end
    chk_true("t1_hs_count", hs_pc.size() >= 3);
    if (hs_pc.size() >= 3) begin
      chk("t1_pc0", hs_pc[0], 32'h0);
      chk("t1_pc1", hs_pc[1], 32'h4);
      chk("t1_pc2", hs_pc[2], 32'h8);
      chk("t1_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd3);
      chk("t1_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd3);
    end

    // Decode stall for 5 cycles in HOLD.
    do_reset();
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; instr_ready = 1'b0;
    wait_valid("t2_valid_timeout");
    held = instr;
    n    = req_log.size();
    chk("t2_held_instr", held, 32'h5A5A_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_stall_instr", instr, held);
      chk("t2_stall_pc", instr_pc, 32'h0);
      chk("t2_stall_noreq", 32'(req_log.size()), 32'(n));
    end
    instr_ready = 1'b1;
    wait_req(n + 1, "t2_req_timeout");
    if (req_log.size() > n) chk("t2_next_addr", req_log[n], 32'h4);

    // Redirect while a request is outstanding; late response is dropped.
    do_reset();
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; instr_ready = 1'b1;
    wait_req(1, "t3_req_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    imem_rsp_valid = 1'b1;
    wait_req(2, "t3_req2_timeout");
    if (req_log.size() >= 2) chk("t3_refetch_addr", req_log[1], 32'h100);
    wait_hs(1, "t3_hs_timeout");
    if (hs_pc.size() >= 1) chk("t3_instr_pc", hs_pc[0], 32'h100);

    // Redirect in HOLD with a same-cycle decode handshake.
    do_reset();
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; instr_ready = 1'b0;
    wait_valid("t4_valid_timeout");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0; instr_ready = 1'b0;
    chk("t4_valid_drop", instr_valid, 1'b0);
    chk("t4_addr", imem_addr, 32'h200);
    chk("t4_squashed", 32'(hs_pc.size()), 32'd0);
    wait_req(2, "t4_req_timeout");
    if (req_log.size() >= 2) chk("t4_fetch_addr", req_log[1], 32'h200);

    // PC wrap at the top of the address space.
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; instr_ready = 1'b1;
    wait_req(2, "t5_req_timeout");
    if (req_log.size() >= 2) begin
      chk("t5_top_addr", req_log[0], 32'hFFFF_FFFC);
      chk("t5_wrap_addr", req_log[1], 32'h0);
    end
    wait_hs(1, "t5_hs_timeout");
    if (hs_pc.size() >= 1) chk("t5_instr_pc", hs_pc[0], 32'hFFFF_FFFC);

    // Misaligned redirect target.
    do_reset();
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("t6_misalign", misalign_err, 1'b1);
    chk("t6_no_req", 32'(req_log.size()), 32'd0);
`else
    chk("t6_misalign", misalign_err, 1'b0);
    chk_true("t6_req_count", req_log.size() >= 1);
    if (req_log.size() >= 1) chk("t6_aligned_addr", req_log[0], 32'h100);
`endif

    // Randomized traffic with occasional mid-transaction resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n          = ($urandom_range(0, 399) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      imem_rsp_valid = ($urandom_range(0, 2) == 0);
      instr_ready    = ($urandom_range(0, 1) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
`ifdef FETCH_MISALIGN_CHK_EN
      redirect_pc    = ($urandom_range(0, 49) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
`else
      redirect_pc    = 32'($urandom);
`endif
    end
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
